// File: rtl/i8088_bus_initiator.sv
// i8088_bus_initiator: minimum-mode 8088-style bus master running T1-T4/TW/TH cycles on AD/A.
// Define WAIT_TIMEOUT_EN to force termination (rsp_err) after MAX_WAIT wait states.
module i8088_bus_initiator #(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  inout  wire  [7:0]  AD,
  output logic [11:0] A,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic        DTR,
  output logic        DEN,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA
);
  typedef enum logic [2:0] {TI, T1, T2, T3, TW, T4, TH} state_t;
  state_t st_q;
  logic        write_q, ad_oe_q, ale_q, iom_q, rd_q, wr_q, dtr_q, den_q, hlda_q, vld_q;
  logic [7:0]  wdata_q, ad_q, rdata_q;
  logic [11:0] a_q;
  logic        done, tmo;
`ifdef WAIT_TIMEOUT_EN
  localparam int CW = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wcnt_q;
  logic          err_q;
  assign tmo     = (st_q == TW) && (wcnt_q == CW'(MAX_WAIT));
  assign rsp_err = err_q;
  // wcnt_q equals the number of TW cycles entered so far in this bus cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= (st_q == T2) ? '0 :
                ((st_q == T3 || st_q == TW) && !done) ? wcnt_q + 1'b1 : wcnt_q;
      err_q  <= (st_q == T3 || st_q == TW) && done && !READY;
    end
  end
`else
  logic [31:0] unused_max_wait;
  assign unused_max_wait = MAX_WAIT;
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign done      = READY | tmo;
  assign req_ready = (st_q == TI) && !HOLD && !RESET;
  assign AD        = ad_oe_q ? ad_q : 8'hzz;
  assign A         = a_q;
  assign ALE       = ale_q;
  assign IOM       = iom_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign DTR       = dtr_q;
  assign DEN       = den_q;
  assign HLDA      = hlda_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q    <= TI;
      write_q <= 1'b0;
      wdata_q <= '0;
      ad_q    <= '0;
      ad_oe_q <= 1'b0;
      a_q     <= '0;
      ale_q   <= 1'b0;
      iom_q   <= 1'b0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      dtr_q   <= 1'b1;
      den_q   <= 1'b1;
      hlda_q  <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      vld_q <= 1'b0;
      case (st_q)
        TI: if (HOLD) begin
          st_q   <= TH;
          hlda_q <= 1'b1;
        end else if (req_valid) begin
          st_q    <= T1;
          write_q <= req_write;
          wdata_q <= req_wdata;
          ad_q    <= req_addr[7:0];
          ad_oe_q <= 1'b1;
          a_q     <= req_addr[19:8];
          iom_q   <= req_io;
          dtr_q   <= req_write;
          ale_q   <= 1'b1;
        end
        T1: begin
          st_q    <= T2;
          ale_q   <= 1'b0;
          ad_q    <= wdata_q;
          ad_oe_q <= write_q;
          rd_q    <= write_q;
          wr_q    <= !write_q;
          den_q   <= 1'b0;
        end
        T2: st_q <= T3;
        T3, TW: if (done) begin
          st_q  <= T4;
          rd_q  <= 1'b1;
          wr_q  <= 1'b1;
          den_q <= 1'b1;
          dtr_q <= 1'b1;
          vld_q <= 1'b1;
          if (!write_q) rdata_q <= READY ? AD : 8'hFF;
        end else st_q <= TW;
        T4: begin
          st_q    <= HOLD ? TH : TI;
          hlda_q  <= HOLD;
          ad_oe_q <= 1'b0;
        end
        TH: if (!HOLD) begin
          st_q   <= TI;
          hlda_q <= 1'b0;
        end
        default: st_q <= TI;
      endcase
    end
  end
endmodule
